mcu_cmd_parser: RTL

MCU_CMD_PARSER -- requirements
Module: mcu_cmd_parser

---
 rtl/mcu_cmd_parser_pkg.sv | 33 +++
 rtl/mcu_cmd_parser_if.sv | 42 ++++
 rtl/mcu_cmd_parser.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mcu_cmd_parser_pkg.sv
// Shared MCU-link constants: frame delimiters, command-type codes and parser state encoding.
// Transmit-side blocks import the same codes so both ends of the link agree.
package mcu_cmd_parser_pkg;

    localparam logic [7:0] START_CODE = 8'hAA;
    localparam logic [7:0] END_CODE   = 8'h55;

    // Payload buffer depth is tied to the 4-bit pl_addr read port.
    localparam int unsigned BUF_DEPTH = 16;

    typedef enum logic [7:0] {
        CMD_NOP   = 8'h00,
        CMD_PING  = 8'h01,
        CMD_READ  = 8'h02,
        CMD_WRITE = 8'h03,
        CMD_RESET = 8'h04
    } cmd_type_e;

    typedef enum logic [2:0] {
        StHunt,
        StCtrl,
        StLenL,
        StLenH,
        StPayload,
        StChk,
        StEndc
    } parser_state_e;

    function automatic logic [7:0] expected_chk(input logic [7:0] sum);
        return ~sum;
    endfunction

endpackage

// File: rtl/mcu_cmd_parser_if.sv
// Byte-stream input and decoded-command output bundle of the MCU command parser.
// The master side feeds UART bytes and reads payload; the slave side is the parser.
interface mcu_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_ok;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;
    logic       cmd_valid;
    logic [7:0] ctrl_code;
    logic [7:0] data_len;
    logic       crc_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_data,
        output rx_ok,
        output pl_addr,
        input  pl_data,
        input  cmd_valid,
        input  ctrl_code,
        input  data_len,
        input  crc_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_data,
        input  rx_ok,
        input  pl_addr,
        output pl_data,
        output cmd_valid,
        output ctrl_code,
        output data_len,
        output crc_err,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/mcu_cmd_parser.sv
// Parses AA/ctrl/len_lo/len_hi/payload/chk/55 frames from a UART byte stream,
// validates length and checksum, and exposes the payload through a read port.
module mcu_cmd_parser
    import mcu_cmd_parser_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst,
    mcu_cmd_parser_if.slave  link
);

    // Lengths above the physical buffer would alias, so clamp the accepted maximum.
    localparam int unsigned MaxLenEff  = (MAX_LEN > BUF_DEPTH) ? BUF_DEPTH : MAX_LEN;
    localparam logic [7:0]  MaxLen     = 8'(MaxLenEff);
    localparam logic [31:0] TimeoutCyc = 32'(TIMEOUT_CYC);

    logic          rx_ok_q1, rx_ok_q2;
    logic [7:0]    rx_byte_q;
    logic          byte_edge;

    parser_state_e state_q, state_d;
    logic [7:0]    ctrl_q, ctrl_d;
    logic [7:0]    len_q, len_d;
    logic [4:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [31:0]   tmo_q, tmo_d;

    logic          cmd_valid_q, cmd_valid_d;
    logic          crc_err_q, crc_err_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    ctrl_code_q, ctrl_code_d;
    logic [7:0]    data_len_q, data_len_d;

    logic [7:0]    buf_q [BUF_DEPTH];
    logic          buf_we;
    logic [3:0]    buf_waddr;

    // Edge registers reset high so a byte already on the line at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ok_q1  <= 1'b1;
            rx_ok_q2  <= 1'b1;
            rx_byte_q <= 8'h00;
        end else begin
            rx_ok_q1  <= link.rx_ok;
            rx_ok_q2  <= rx_ok_q1;
            rx_byte_q <= link.rx_data;
        end
    end

    assign byte_edge = rx_ok_q1 & ~rx_ok_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            ctrl_q      <= 8'h00;
            len_q       <= 8'h00;
            idx_q       <= 5'd0;
            sum_q       <= 8'h00;
            tmo_q       <= 32'd0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ctrl_code_q <= 8'h00;
            data_len_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            cmd_valid_q <= cmd_valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            ctrl_code_q <= ctrl_code_d;
            data_len_q  <= data_len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else if (buf_we) begin
            buf_q[buf_waddr] <= rx_byte_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        cmd_valid_d = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        ctrl_code_d = ctrl_code_q;
        data_len_d  = data_len_q;
        buf_we      = 1'b0;
        buf_waddr   = idx_q[3:0];

        if (byte_edge) begin
            // A byte edge always wins over a coincident timeout.
            tmo_d = 32'd0;
            unique case (state_q)
                StHunt: begin
                    if (rx_byte_q == START_CODE) begin
                        state_d = StCtrl;
                        sum_d   = 8'h00;
                        idx_d   = 5'd0;
                    end
                end
                StCtrl: begin
                    ctrl_d  = rx_byte_q;
                    sum_d   = rx_byte_q;
                    state_d = StLenL;
                end
                StLenL: begin
                    len_d   = rx_byte_q;
                    sum_d   = sum_q + rx_byte_q;
                    state_d = StLenH;
                end
                StLenH: begin
                    if ((rx_byte_q != 8'h00) || (len_q > MaxLen)) begin
                        frame_err_d = 1'b1;
                        state_d     = StHunt;
                    end else begin
                        sum_d   = sum_q + rx_byte_q;
                        idx_d   = 5'd0;
                        state_d = (len_q == 8'h00) ? StChk : StPayload;
                    end
                end
                StPayload: begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + rx_byte_q;
                    idx_d  = idx_q + 5'd1;
                    if ({3'b000, idx_d} == len_q) begin
                        state_d = StChk;
                    end
                end
                StChk: begin
                    if (rx_byte_q == expected_chk(sum_q)) begin
                        state_d = StEndc;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = StHunt;
                    end
                end
                StEndc: begin
                    if (rx_byte_q == END_CODE) begin
                        cmd_valid_d = 1'b1;
                        ctrl_code_d = ctrl_q;
                        data_len_d  = len_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = StHunt;
                end
                default: state_d = StHunt;
            endcase
        end else if (state_q == StHunt) begin
            tmo_d = 32'd0;
        end else if (tmo_q + 32'd1 >= TimeoutCyc) begin
            frame_err_d = 1'b1;
            state_d     = StHunt;
            tmo_d       = 32'd0;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    assign link.cmd_valid = cmd_valid_q;
    assign link.crc_err   = crc_err_q;
    assign link.frame_err = frame_err_q;
    assign link.ctrl_code = ctrl_code_q;
    assign link.data_len  = data_len_q;
    assign link.busy      = (state_q != StHunt);
    assign link.pl_data   = buf_q[link.pl_addr];

endmodule
